io_bus_sequencer: RTL and testbench

//  Upstream stage of the 3-to-8 chip-select decoder in the multi-cycle MIPS I/O path.

---
 rtl/io_bus_sequencer.sv | 136 +++++++++++++
 tb/tb_io_bus_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_sequencer.sv
// Sequences one CPU load/store onto the 3-to-8 chip-select decoder pins
// through SETUP, STROBE and HOLD phases; every output is a registered decode of the next state.
module io_bus_sequencer #(
    parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
    parameter logic [31:0] IO_MASK     = 32'hFFFF_0000,
    parameter int unsigned SEL_LSB     = 4,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic        err,
    output logic [31:0] rdata,
    output logic [2:0]  dec_a,
    output logic        dec_g1,
    output logic        dec_g2a_n,
    output logic        dec_g2b_n,
    output logic        io_we_n,
    output logic        io_oe_n,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [3:0] HOLD_LAST = 4'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    state_t      state, state_nx;
    logic [2:0]  sel, sel_nx;
    logic        we_q, we_nx;
    logic        miss, miss_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] rdata_nx;
    logic [31:0] io_wdata_nx;
    logic        hit;
    logic        active_nx;
    logic        strobe_nx;

    assign hit = ((addr & IO_MASK) == IO_BASE);

    always_comb begin
        state_nx    = state;
        sel_nx      = sel;
        we_nx       = we_q;
        miss_nx     = miss;
        cnt_nx      = cnt;
        rdata_nx    = rdata;
        io_wdata_nx = io_wdata;
        case (state)
            IDLE: begin
                if (req) begin
                    sel_nx = addr[SEL_LSB+2:SEL_LSB];
                    we_nx  = we;
                    cnt_nx = 4'd0;
                    if (hit) begin
                        miss_nx     = 1'b0;
                        io_wdata_nx = wdata;
                        state_nx    = SETUP;
                    end else begin
                        miss_nx  = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            SETUP: begin
                cnt_nx   = 4'd0;
                state_nx = STROBE;
            end
            STROBE: begin
                // Read data is taken from the device while the strobe is still asserted.
                if (cnt == WAIT_LAST) begin
                    if (!we_q) rdata_nx = io_rdata;
                    cnt_nx   = 4'd0;
                    state_nx = (HOLD_CYCLES == 0) ? DONE : HOLD;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) state_nx = DONE;
                else cnt_nx = cnt + 4'd1;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign active_nx = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
    assign strobe_nx = (state_nx == STROBE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            we_q      <= 1'b0;
            miss      <= 1'b0;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            dec_a     <= 3'd0;
            dec_g1    <= 1'b0;
            dec_g2a_n <= 1'b1;
            dec_g2b_n <= 1'b1;
            io_we_n   <= 1'b1;
            io_oe_n   <= 1'b1;
            io_wdata  <= 32'd0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            we_q      <= we_nx;
            miss      <= miss_nx;
            cnt       <= cnt_nx;
            busy      <= (state_nx != IDLE);
            ready     <= (state_nx == DONE);
            err       <= (state_nx == DONE) && miss_nx;
            rdata     <= rdata_nx;
            dec_a     <= active_nx ? sel_nx : 3'd0;
            dec_g1    <= strobe_nx;
            dec_g2a_n <= !strobe_nx;
            dec_g2b_n <= !strobe_nx;
            io_we_n   <= !(strobe_nx && we_nx);
            io_oe_n   <= !(strobe_nx && !we_nx);
            io_wdata  <= io_wdata_nx;
        end
    end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Bench for io_bus_sequencer: four instances with different wait/hold settings,
// a small device memory model and a scoreboard of expected completions.
module tb_io_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_s = 1'b0;
    logic [31:0] addr_s = '0;
    logic [31:0] wdata_s = '0;
    logic [31:0] dev_mem [8];

    logic        req_v [4];
    logic        busy_v [4];
    logic        ready_v [4];
    logic        err_v [4];
    logic [31:0] rdata_v [4];
    logic [2:0]  dec_a_v [4];
    logic        dec_g1_v [4];
    logic        dec_g2a_n_v [4];
    logic        dec_g2b_n_v [4];
    logic        io_we_n_v [4];
    logic        io_oe_n_v [4];
    logic [31:0] io_wdata_v [4];
    logic [31:0] io_rdata_v [4];

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        int          lat;
        int          en_cyc;
        int          first_en;
        int          we_cyc;
        int          oe_cyc;
        int          bad;
        int          idle_cyc;
        int          deca_nz;
        logic [2:0]  deca_en;
        logic [31:0] wdata_en;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Instance 0 default, 1 with two wait states, 2 with three, 3 without HOLD.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        io_bus_sequencer #(
            .WAIT_CYCLES((g == 1) ? 2 : (g == 2) ? 3 : 0),
            .HOLD_CYCLES((g == 3) ? 0 : 1)
        ) dut (
            .clk(clk), .rst_n(rst_n), .req(req_v[g]), .we(we_s), .addr(addr_s), .wdata(wdata_s),
            .busy(busy_v[g]), .ready(ready_v[g]), .err(err_v[g]), .rdata(rdata_v[g]),
            .dec_a(dec_a_v[g]), .dec_g1(dec_g1_v[g]), .dec_g2a_n(dec_g2a_n_v[g]),
            .dec_g2b_n(dec_g2b_n_v[g]), .io_we_n(io_we_n_v[g]), .io_oe_n(io_oe_n_v[g]),
            .io_wdata(io_wdata_v[g]), .io_rdata(io_rdata_v[g])
        );
        assign io_rdata_v[g] = dev_mem[dec_a_v[g]];
    end

    task automatic apply_stimulus(input int idx, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic hold_req);
        @(negedge clk);
        req_v[idx] = 1'b1;
        we_s = w;
        addr_s = a;
        wdata_s = d;
        @(posedge clk);
        #1;
        if (!hold_req) req_v[idx] = 1'b0;
    endtask

    // Records bus activity each cycle until ready (lat stays -1 on timeout).
    task automatic monitor(input int idx, input int budget, output obs_t o);
        o = '{lat: -1, en_cyc: 0, first_en: 0, we_cyc: 0, oe_cyc: 0, bad: 0, idle_cyc: 0,
              deca_nz: 0, deca_en: 3'd0, wdata_en: 32'd0, rdata: 32'd0, err: 1'b0};
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (dec_g1_v[idx]) begin
                o.en_cyc++;
                if (o.first_en == 0) o.first_en = n;
                o.deca_en = dec_a_v[idx];
                o.wdata_en = io_wdata_v[idx];
            end
            if (!io_we_n_v[idx]) o.we_cyc++;
            if (!io_oe_n_v[idx]) o.oe_cyc++;
            if (!io_we_n_v[idx] && !io_oe_n_v[idx]) o.bad++;
            if ((!io_we_n_v[idx] || !io_oe_n_v[idx]) && !dec_g1_v[idx]) o.bad++;
            if (dec_g1_v[idx] !== !dec_g2a_n_v[idx] || dec_g1_v[idx] !== !dec_g2b_n_v[idx]) o.bad++;
            if (!busy_v[idx]) o.idle_cyc++;
            if (dec_a_v[idx] != 3'd0) o.deca_nz++;
            if (ready_v[idx]) begin
                o.lat = n;
                o.rdata = rdata_v[idx];
                o.err = err_v[idx];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({busy_v[i], ready_v[i], err_v[i], dec_a_v[i], dec_g1_v[i], dec_g2a_n_v[i], dec_g2b_n_v[i], io_we_n_v[i], io_oe_n_v[i]} !== 11'b000_000_0_1111) $display("[TB] FAIL reset_ctrl dut%0d: got %b expected 00000001111", i, {busy_v[i], ready_v[i], err_v[i], dec_a_v[i], dec_g1_v[i], dec_g2a_n_v[i], dec_g2b_n_v[i], io_we_n_v[i], io_oe_n_v[i]}); else passes++;
            checks++; if ({rdata_v[i], io_wdata_v[i]} !== 64'd0) $display("[TB] FAIL reset_data dut%0d: got %h expected 0", i, {rdata_v[i], io_wdata_v[i]}); else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_default();
        obs_t o;
        exp_t e;
        apply_stimulus(0, 1'b0, 32'hFFFF_0030, 32'h0, 1'b0);
        sb.push_back('{32'hDEAD_BEEF, 1'b0, 4});
        monitor(0, 20, o);
        e = sb.pop_front();
        checks++; if (o.lat !== e.lat) $display("[TB] FAIL read_latency: got %0d expected %0d", o.lat, e.lat); else passes++;
        checks++; if (o.rdata !== e.rdata) $display("[TB] FAIL read_rdata: got %h expected %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.err !== e.err) $display("[TB] FAIL read_err: got %b expected %b", o.err, e.err); else passes++;
        checks++; if (o.first_en !== 2 || o.en_cyc !== 1) $display("[TB] FAIL read_enable: got first %0d count %0d expected 2 1", o.first_en, o.en_cyc); else passes++;
        checks++; if (o.deca_en !== 3'd3) $display("[TB] FAIL read_dec_a: got %0d expected 3", o.deca_en); else passes++;
        checks++; if (o.oe_cyc !== 1 || o.we_cyc !== 0) $display("[TB] FAIL read_strobes: got oe %0d we %0d expected 1 0", o.oe_cyc, o.we_cyc); else passes++;
        checks++; if (o.bad !== 0 || o.idle_cyc !== 0) $display("[TB] FAIL read_protocol: got bad %0d idle %0d expected 0 0", o.bad, o.idle_cyc); else passes++;
    endtask

    task automatic test_write_wait();
        obs_t o;
        exp_t e;
        apply_stimulus(1, 1'b1, 32'hFFFF_0050, 32'h1234_5678, 1'b0);
        sb.push_back('{32'h0, 1'b0, 6});
        monitor(1, 30, o);
        e = sb.pop_front();
        checks++; if (o.lat !== e.lat) $display("[TB] FAIL write_latency: got %0d expected %0d", o.lat, e.lat); else passes++;
        checks++; if (o.rdata !== e.rdata) $display("[TB] FAIL write_rdata_kept: got %h expected %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.err !== e.err) $display("[TB] FAIL write_err: got %b expected %b", o.err, e.err); else passes++;
        checks++; if (o.we_cyc !== 3 || o.oe_cyc !== 0) $display("[TB] FAIL write_strobes: got we %0d oe %0d expected 3 0", o.we_cyc, o.oe_cyc); else passes++;
        checks++; if (o.deca_en !== 3'd5) $display("[TB] FAIL write_dec_a: got %0d expected 5", o.deca_en); else passes++;
        checks++; if (o.wdata_en !== 32'h1234_5678) $display("[TB] FAIL write_io_wdata: got %h expected 12345678", o.wdata_en); else passes++;
        checks++; if (o.bad !== 0) $display("[TB] FAIL write_protocol: got %0d expected 0", o.bad); else passes++;
    endtask

    task automatic test_miss();
        obs_t o;
        exp_t e;
        apply_stimulus(0, 1'b0, 32'h0000_1000, 32'h0, 1'b0);
        sb.push_back('{32'hDEAD_BEEF, 1'b1, 1});
        monitor(0, 10, o);
        e = sb.pop_front();
        checks++; if (o.lat !== e.lat) $display("[TB] FAIL miss_latency: got %0d expected %0d", o.lat, e.lat); else passes++;
        checks++; if (o.err !== e.err) $display("[TB] FAIL miss_err: got %b expected %b", o.err, e.err); else passes++;
        checks++; if (o.rdata !== e.rdata) $display("[TB] FAIL miss_rdata_kept: got %h expected %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.en_cyc !== 0 || o.deca_nz !== 0) $display("[TB] FAIL miss_decoder_quiet: got en %0d dec_a %0d expected 0 0", o.en_cyc, o.deca_nz); else passes++;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        exp_t e;
        apply_stimulus(0, 1'b0, 32'hFFFF_0010, 32'h0, 1'b1);
        sb.push_back('{32'h1111_1111, 1'b0, 4});
        sb.push_back('{32'h7777_7777, 1'b0, 5});
        addr_s = 32'hFFFF_0070;
        monitor(0, 20, o1);
        monitor(0, 20, o2);
        req_v[0] = 1'b0;
        e = sb.pop_front();
        checks++; if (o1.lat !== e.lat || o1.rdata !== e.rdata) $display("[TB] FAIL b2b_first: got lat %0d rdata %h expected %0d %h", o1.lat, o1.rdata, e.lat, e.rdata); else passes++;
        e = sb.pop_front();
        checks++; if (o2.lat !== e.lat || o2.rdata !== e.rdata) $display("[TB] FAIL b2b_second: got lat %0d rdata %h expected %0d %h", o2.lat, o2.rdata, e.lat, e.rdata); else passes++;
        checks++; if (o2.idle_cyc !== 1) $display("[TB] FAIL b2b_idle_gap: got %0d expected 1", o2.idle_cyc); else passes++;
        checks++; if (o1.deca_en !== 3'd1 || o2.deca_en !== 3'd7) $display("[TB] FAIL b2b_dec_a: got %0d %0d expected 1 7", o1.deca_en, o2.deca_en); else passes++;
        checks++; if (o1.bad + o2.bad !== 0 || o1.en_cyc + o2.en_cyc !== 2) $display("[TB] FAIL b2b_protocol: got bad %0d en %0d expected 0 2", o1.bad + o2.bad, o1.en_cyc + o2.en_cyc); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (busy_v[0] !== 1'b0) $display("[TB] FAIL b2b_no_third: got busy %b expected 0", busy_v[0]); else passes++;
    endtask

    task automatic test_no_hold();
        obs_t o;
        exp_t e;
        apply_stimulus(3, 1'b0, 32'hFFFF_0020, 32'h0, 1'b0);
        sb.push_back('{32'h2222_2222, 1'b0, 3});
        monitor(3, 20, o);
        e = sb.pop_front();
        checks++; if (o.lat !== e.lat) $display("[TB] FAIL nohold_latency: got %0d expected %0d", o.lat, e.lat); else passes++;
        checks++; if (o.rdata !== e.rdata) $display("[TB] FAIL nohold_rdata: got %h expected %h", o.rdata, e.rdata); else passes++;
        checks++; if (o.en_cyc !== 1 || o.first_en !== 2) $display("[TB] FAIL nohold_enable: got count %0d first %0d expected 1 2", o.en_cyc, o.first_en); else passes++;
    endtask

    task automatic test_reset_mid_strobe();
        int pulses = 0;
        int busy_seen = 0;
        apply_stimulus(2, 1'b0, 32'hFFFF_0040, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (dec_g1_v[2] !== 1'b1) $display("[TB] FAIL midrst_in_strobe: got %b expected 1", dec_g1_v[2]); else passes++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({dec_g1_v[2], dec_g2a_n_v[2], dec_g2b_n_v[2], io_oe_n_v[2], io_we_n_v[2]} !== 5'b01111) $display("[TB] FAIL midrst_enables: got %b expected 01111", {dec_g1_v[2], dec_g2a_n_v[2], dec_g2b_n_v[2], io_oe_n_v[2], io_we_n_v[2]}); else passes++;
        checks++; if (busy_v[2] !== 1'b0 || ready_v[2] !== 1'b0) $display("[TB] FAIL midrst_status: got busy %b ready %b expected 0 0", busy_v[2], ready_v[2]); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ready_v[2] !== 1'b0) pulses++;
            if (busy_v[2] !== 1'b0) busy_seen++;
        end
        checks++; if (pulses !== 0 || busy_seen !== 0) $display("[TB] FAIL midrst_quiet_after: got ready %0d busy %0d expected 0 0", pulses, busy_seen); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_v[i] = 1'b0;
        for (int i = 0; i < 8; i++) dev_mem[i] = {8{i[3:0]}};
        dev_mem[3] = 32'hDEAD_BEEF;
        test_reset();
        test_read_default();
        test_write_wait();
        test_miss();
        test_back_to_back();
        test_no_hold();
        test_reset_mid_strobe();
        checks++; if (sb.size() !== 0) $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
